// File: rtl/lcd_rgb_timing_if.sv
// Bus between the RGB-LCD timing generator, the pattern/display stage and the
// panel pins. The master modport is the timing generator itself. The slave
// modport is the display stage plus the panel side.
interface lcd_rgb_timing_if;
    logic        lcd_en;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        pos_valid;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        frame_start;
    logic        busy;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;

    modport master (
        input  lcd_en, pixel_data,
        output pixel_xpos, pixel_ypos, pos_valid, h_disp, v_disp,
               frame_start, busy, lcd_hs, lcd_vs, lcd_de, lcd_rgb
    );

    modport slave (
        output lcd_en, pixel_data,
        input  pixel_xpos, pixel_ypos, pos_valid, h_disp, v_disp,
               frame_start, busy, lcd_hs, lcd_vs, lcd_de, lcd_rgb
    );
endinterface

// File: rtl/lcd_rgb_timing.sv
// RGB-LCD timing generator and pixel output stage.
// The module publishes pixel coordinates one cycle after the counters. It then
// expects the display stage's registered pixel_data one cycle later. Finally it
// drives HS/VS/DE/RGB three cycles after the counter cycle, all on one alignment.
// Scanning starts and stops only on frame boundaries.
// Optional feature: define LCD_TIMING_BLANK_BLACK_EN to force lcd_rgb to black
// whenever the delayed DE is low.
module lcd_rgb_timing #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic              lcd_pclk,
    input  logic              rst,
    lcd_rgb_timing_if.master  bus
);
    localparam logic [10:0] H_TOTAL   = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [10:0] V_TOTAL   = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BACK + V_DISP);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t      state_q;
    logic        busy_q;
    logic [10:0] h_cnt_q, v_cnt_q;
    logic [10:0] h_cnt_d, v_cnt_d;
    logic        h_last, v_last, frame_last;

    logic        scanning, hs_act, vs_act, act;

    logic        pos_valid_q, frame_start_q;
    logic [10:0] xpos_q, ypos_q;
    logic [2:0]  hs_pipe_q, vs_pipe_q, de_pipe_q;
    logic [23:0] rgb_q;

    assign h_last     = (h_cnt_q == H_TOTAL - 11'd1);
    assign v_last     = (v_cnt_q == V_TOTAL - 11'd1);
    assign frame_last = h_last && v_last;

    // Free-running counter increment with line and frame wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    // Start/stop FSM. It owns the counters and the registered busy flag.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (bus.lcd_en) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    h_cnt_q <= h_cnt_d;
                    v_cnt_q <= v_cnt_d;
                    if (!bus.lcd_en) state_q <= STOP;
                end
                STOP: begin
                    h_cnt_q <= h_cnt_d;
                    v_cnt_q <= v_cnt_d;
                    // A request seen on the final count keeps scanning seamlessly.
                    if (bus.lcd_en) begin
                        state_q <= RUN;
                    end else if (frame_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                end
            endcase
        end
    end

    // Counter decodes. While IDLE the counters are held at 0, so the decodes
    // are gated off.
    assign scanning = (state_q != IDLE);
    assign hs_act   = scanning && (h_cnt_q < H_SYNC_W);
    assign vs_act   = scanning && (v_cnt_q < V_SYNC_W);
    assign act      = scanning &&
                      (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                      (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);

    // First stage: coordinates and frame marker handed to the display stage.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            pos_valid_q   <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pos_valid_q   <= act;
            xpos_q        <= act ? h_cnt_q - H_ACT_BEG : 11'd0;
            ypos_q        <= act ? v_cnt_q - V_ACT_BEG : 11'd0;
            frame_start_q <= scanning && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        end
    end

    // Three-deep delay line so sync/DE meet the display stage's returned pixel.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
        end else begin
            hs_pipe_q <= {hs_pipe_q[1:0], hs_act};
            vs_pipe_q <= {vs_pipe_q[1:0], vs_act};
            de_pipe_q <= {de_pipe_q[1:0], act};
        end
    end

    // Output pixel register. de_pipe_q[1] becomes the visible DE on the same edge.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
`ifdef LCD_TIMING_BLANK_BLACK_EN
            rgb_q <= de_pipe_q[1] ? bus.pixel_data : 24'h000000;
`else
            rgb_q <= bus.pixel_data;
`endif
        end
    end

    assign bus.pixel_xpos  = xpos_q;
    assign bus.pixel_ypos  = ypos_q;
    assign bus.pos_valid   = pos_valid_q;
    assign bus.h_disp      = 11'(H_DISP);
    assign bus.v_disp      = 11'(V_DISP);
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.lcd_hs      = hs_pipe_q[2] ? HS_POL : ~HS_POL;
    assign bus.lcd_vs      = vs_pipe_q[2] ? VS_POL : ~VS_POL;
    assign bus.lcd_de      = de_pipe_q[2];
    assign bus.lcd_rgb     = rgb_q;
endmodule

// File: tb/tb_lcd_rgb_timing.sv
// Directed bench for lcd_rgb_timing using a shrunken raster so that whole
// frames stay short. A small display-stage model registers {xpos,ypos}, or a
// constant white, back into pixel_data.
module tb_lcd_rgb_timing;
    localparam int HS = 3, HB = 2, HD = 6, HF = 2;
    localparam int VS = 2, VB = 1, VD = 4, VF = 1;
    localparam int HT = HS + HB + HD + HF;   // 13
    localparam int VT = VS + VB + VD + VF;   // 8
    localparam int FRAME = HT * VT;          // 104

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic const_mode = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lcd_rgb_timing_if bus();

    lcd_rgb_timing #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .lcd_pclk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Display-stage model: one register from the coordinates to pixel_data.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.pixel_data <= 24'd0;
        else     bus.pixel_data <= const_mode ? 24'hFFFFFF : {2'b00, bus.pixel_xpos, bus.pixel_ypos};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.lcd_en = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.busy, bus.pos_valid, bus.frame_start, bus.lcd_hs, bus.lcd_vs, bus.lcd_de} !== 6'b000110) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000110",
                     {bus.busy, bus.pos_valid, bus.frame_start, bus.lcd_hs, bus.lcd_vs, bus.lcd_de});
        end
        checks++;
        if ({bus.pixel_xpos, bus.pixel_ypos} !== 22'd0) begin
            failures++; $display("FAIL reset_pos: got %h want 0", {bus.pixel_xpos, bus.pixel_ypos});
        end
        checks++;
        if (bus.lcd_rgb !== 24'd0) begin
            failures++; $display("FAIL reset_rgb: got %h want 000000", bus.lcd_rgb);
        end
        checks++;
        if (bus.h_disp !== 11'(HD) || bus.v_disp !== 11'(VD)) begin
            failures++; $display("FAIL disp_size: got %0d x %0d want %0d x %0d", bus.h_disp, bus.v_disp, HD, VD);
        end
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_release: busy=%b want 0", bus.busy);
        end
        $display("reset: done");
    endtask

    // lcd_en sampled in IDLE: busy +1, frame_start +2, first HS active +4.
    task automatic test_startup();
        bus.lcd_en = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.frame_start !== 1'b0) begin
            failures++; $display("FAIL start_p1: busy=%b fs=%b want 1 0", bus.busy, bus.frame_start);
        end
        tick();
        checks++;
        if (bus.frame_start !== 1'b1) begin
            failures++; $display("FAIL start_p2: frame_start=%b want 1", bus.frame_start);
        end
        tick();
        checks++;
        if (bus.lcd_hs !== 1'b1) begin
            failures++; $display("FAIL start_p3: lcd_hs=%b want 1", bus.lcd_hs);
        end
        tick();
        checks++;
        if (bus.lcd_hs !== 1'b0) begin
            failures++; $display("FAIL start_p4: lcd_hs=%b want 0", bus.lcd_hs);
        end
        repeat (FRAME - 2) tick();
        checks++;
        if (bus.frame_start !== 1'b1) begin
            failures++; $display("FAIL start_frame2: frame_start=%b want 1", bus.frame_start);
        end
        $display("startup: done");
    endtask

    // Entry and exit on a frame_start cycle; count pin activity over one frame.
    task automatic test_frame();
        int hs_low = 0, vs_low = 0, de_hi = 0, fs = 0, run = 0, runs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (bus.lcd_hs === 1'b0) hs_low++;
            if (bus.lcd_vs === 1'b0) vs_low++;
            if (bus.frame_start === 1'b1) fs++;
            if (bus.lcd_de === 1'b1) begin
                de_hi++; run++;
            end else if (run != 0) begin
                runs++;
                checks++;
                if (run != HD) begin
                    failures++; $display("FAIL de_run_len: got %0d want %0d", run, HD);
                end
                run = 0;
            end
            tick();
        end
        checks++;
        if (hs_low != HS * VT) begin failures++; $display("FAIL hs_low: got %0d want %0d", hs_low, HS * VT); end
        checks++;
        if (vs_low != VS * HT) begin failures++; $display("FAIL vs_low: got %0d want %0d", vs_low, VS * HT); end
        checks++;
        if (de_hi != HD * VD) begin failures++; $display("FAIL de_total: got %0d want %0d", de_hi, HD * VD); end
        checks++;
        if (runs != VD) begin failures++; $display("FAIL de_lines: got %0d want %0d", runs, VD); end
        checks++;
        if (fs != 1 || bus.frame_start !== 1'b1) begin
            failures++; $display("FAIL fs_spacing: pulses=%0d now=%b want 1 1", fs, bus.frame_start);
        end
        $display("frame: hs_low=%0d vs_low=%0d de=%0d", hs_low, vs_low, de_hi);
    endtask

    task automatic test_alignment();
        int pv_at = -1, de_at = -1, ex = 0, ey = 0, pv_cnt = 0;
        logic [23:0] exp_rgb;
        for (int i = 0; i < FRAME; i++) begin
            if (bus.pos_valid === 1'b1) begin
                pv_cnt++;
                if (pv_at < 0) begin
                    pv_at = i;
                    checks++;
                    if (bus.pixel_xpos !== 11'd0 || bus.pixel_ypos !== 11'd0) begin
                        failures++; $display("FAIL first_pos: got %0d,%0d want 0,0", bus.pixel_xpos, bus.pixel_ypos);
                    end
                end
            end else begin
                checks++;
                if (bus.pixel_xpos !== 11'd0 || bus.pixel_ypos !== 11'd0) begin
                    failures++; $display("FAIL pos_invalid_zero: got %0d,%0d want 0,0", bus.pixel_xpos, bus.pixel_ypos);
                end
            end
            if (bus.lcd_de === 1'b1) begin
                if (de_at < 0) de_at = i;
                exp_rgb = {2'b00, 11'(ex), 11'(ey)};
                checks++;
                if (bus.lcd_rgb !== exp_rgb) begin
                    failures++; $display("FAIL rgb_pixel: got %h want %h", bus.lcd_rgb, exp_rgb);
                end
                if (ex == HD - 1) begin
                    checks++;
                    if (bus.lcd_rgb[21:11] !== 11'(HD - 1)) begin
                        failures++; $display("FAIL last_de_x: got %0d want %0d", bus.lcd_rgb[21:11], HD - 1);
                    end
                    ex = 0; ey++;
                end else begin
                    ex++;
                end
            end
            tick();
        end
        checks++;
        if (pv_at < 0 || de_at - pv_at != 2) begin
            failures++; $display("FAIL de_lag: got %0d want 2", de_at - pv_at);
        end
        checks++;
        if (pv_cnt != HD * VD) begin failures++; $display("FAIL pv_total: got %0d want %0d", pv_cnt, HD * VD); end
        $display("alignment: pv_at=%0d de_at=%0d", pv_at, de_at);
    endtask

    // Entry on frame_start. Drop lcd_en at line 3; the frame must complete.
    task automatic test_graceful_stop();
        int n = 0, de_cnt = 0, idle_evt = 0;
        repeat (3 * HT) begin
            if (bus.lcd_de === 1'b1) de_cnt++;
            tick(); n++;
        end
        bus.lcd_en = 1'b0;
        while (bus.busy === 1'b1 && n < 3 * FRAME) begin
            if (bus.lcd_de === 1'b1) de_cnt++;
            tick(); n++;
        end
        checks++;
        if (n != FRAME - 1) begin failures++; $display("FAIL stop_busy_drop: at %0d want %0d", n, FRAME - 1); end
        checks++;
        if (de_cnt != HD * VD) begin failures++; $display("FAIL stop_full_frame: de=%0d want %0d", de_cnt, HD * VD); end
        tick(); tick(); tick();
        repeat (2 * FRAME) begin
            if (bus.lcd_de !== 1'b0 || bus.frame_start !== 1'b0 || bus.busy !== 1'b0 || bus.lcd_hs !== 1'b1)
                idle_evt++;
            tick();
        end
        checks++;
        if (idle_evt != 0) begin failures++; $display("FAIL stop_idle: active cycles=%0d want 0", idle_evt); end
        $display("graceful_stop: busy dropped at %0d", n);
    endtask

    task automatic test_reenable();
        int busy_low = 0, fs_mid = 0, de_cnt = 0;
        bus.lcd_en = 1'b1;
        tick(); tick();
        checks++;
        if (bus.frame_start !== 1'b1) begin failures++; $display("FAIL reen_start: fs=%b want 1", bus.frame_start); end
        for (int n = 0; n < FRAME; n++) begin
            if (n == 2 * HT) bus.lcd_en = 1'b0;
            if (n == 5 * HT) bus.lcd_en = 1'b1;
            if (n > 0 && bus.frame_start === 1'b1) fs_mid++;
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.lcd_de === 1'b1) de_cnt++;
            tick();
        end
        checks++;
        if (bus.frame_start !== 1'b1 || fs_mid != 0 || busy_low != 0) begin
            failures++; $display("FAIL reen_mid: fs=%b mid=%0d busy_low=%0d want 1 0 0", bus.frame_start, fs_mid, busy_low);
        end
        checks++;
        if (de_cnt != HD * VD) begin failures++; $display("FAIL reen_de: got %0d want %0d", de_cnt, HD * VD); end
        busy_low = 0; fs_mid = 0;
        // lcd_en returns exactly on the final count of the frame
        for (int n = 0; n < FRAME; n++) begin
            if (n == 2 * HT) bus.lcd_en = 1'b0;
            if (n == FRAME - 2) bus.lcd_en = 1'b1;
            if (n > 0 && bus.frame_start === 1'b1) fs_mid++;
            if (bus.busy !== 1'b1) busy_low++;
            tick();
        end
        checks++;
        if (bus.frame_start !== 1'b1 || fs_mid != 0 || busy_low != 0) begin
            failures++; $display("FAIL reen_last: fs=%b mid=%0d busy_low=%0d want 1 0 0", bus.frame_start, fs_mid, busy_low);
        end
        $display("reenable: done");
    endtask

    // Entry on frame_start while running. Reset lands mid-line in the active area.
    task automatic test_async_reset();
        int evt = 0;
        repeat (HT * (VS + VB + 1) + HS + HB + 4) tick();
        checks++;
        if (bus.pos_valid !== 1'b1 || bus.lcd_de !== 1'b1 || bus.lcd_rgb === 24'd0) begin
            failures++; $display("FAIL pre_rst_active: pv=%b de=%b rgb=%h want 1 1 nonzero", bus.pos_valid, bus.lcd_de, bus.lcd_rgb);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.pos_valid, bus.frame_start, bus.lcd_hs, bus.lcd_vs, bus.lcd_de} !== 6'b000110 ||
            {bus.pixel_xpos, bus.pixel_ypos} !== 22'd0 || bus.lcd_rgb !== 24'd0) begin
            failures++; $display("FAIL async_rst: ctrl=%b pos=%h rgb=%h want 000110 0 0",
                {bus.busy, bus.pos_valid, bus.frame_start, bus.lcd_hs, bus.lcd_vs, bus.lcd_de},
                {bus.pixel_xpos, bus.pixel_ypos}, bus.lcd_rgb);
        end
        bus.lcd_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2 * FRAME) begin
            if (bus.busy !== 1'b0 || bus.frame_start !== 1'b0 || bus.lcd_de !== 1'b0) evt++;
            tick();
        end
        checks++;
        if (evt != 0) begin failures++; $display("FAIL rst_idle_hold: active cycles=%0d want 0", evt); end
        bus.lcd_en = 1'b1;
        tick(); tick();
        checks++;
        if (bus.frame_start !== 1'b1) begin failures++; $display("FAIL rst_restart: fs=%b want 1", bus.frame_start); end
        $display("async_reset: done");
    endtask

    task automatic test_blanking();
        logic [23:0] blank_val;
`ifdef LCD_TIMING_BLANK_BLACK_EN
        blank_val = 24'h000000;
`else
        blank_val = 24'hFFFFFF;
`endif
        const_mode = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (bus.lcd_de === 1'b1) begin
                if (bus.lcd_rgb !== 24'hFFFFFF) begin
                    failures++; $display("FAIL blank_de_rgb: got %h want FFFFFF", bus.lcd_rgb);
                end
            end else if (bus.lcd_rgb !== blank_val) begin
                failures++; $display("FAIL blank_rgb: got %h want %h", bus.lcd_rgb, blank_val);
            end
            tick();
        end
        $display("blanking: blank value %h", blank_val);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_frame();
        test_alignment();
        test_graceful_stop();
        test_reenable();
        test_async_reset();
        test_blanking();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
